// File: rtl/tlights_pkg.sv
// Shared light encodings and junction phase codes, used by the junction sequencer
// and by the per-head light logic.
package tlights_pkg;

    typedef logic [2:0] rag_t;  // {red, amber, green}

    localparam rag_t RED      = 3'b100;
    localparam rag_t REDAMBER = 3'b110;
    localparam rag_t GREEN    = 3'b001;
    localparam rag_t AMBER    = 3'b010;

    typedef enum logic [3:0] {
        PH_MG   = 4'd0,
        PH_MA   = 4'd1,
        PH_AR1  = 4'd2,
        PH_WALK = 4'd3,
        PH_SRA  = 4'd4,
        PH_SG   = 4'd5,
        PH_SA   = 4'd6,
        PH_AR2  = 4'd7,
        PH_MRA  = 4'd8
    } phase_t;

    // Unknown phase codes fall to red so a corrupted phase never shows a conflict.
    function automatic rag_t main_rag(input phase_t p);
        main_rag = RED;
        case (p)
            PH_MG:   main_rag = GREEN;
            PH_MA:   main_rag = AMBER;
            PH_MRA:  main_rag = REDAMBER;
            default: main_rag = RED;
        endcase
    endfunction

    function automatic rag_t side_rag(input phase_t p);
        side_rag = RED;
        case (p)
            PH_SRA:  side_rag = REDAMBER;
            PH_SG:   side_rag = GREEN;
            PH_SA:   side_rag = AMBER;
            default: side_rag = RED;
        endcase
    endfunction

endpackage

// File: rtl/tlights_dwell_timer.sv
// Phase dwell down-counter: loads on strobe, counts down to zero and parks there.
module tlights_dwell_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tlights_junction.sv
// Two-road junction sequencer: main road rests on green, side phase on latched request.
// Optional pedestrian all-red walk phase is built when TLJ_PED_EN is defined.
module tlights_junction #(
    parameter int T_MAIN_MIN   = 8,
    parameter int T_SIDE_GREEN = 6,
    parameter int T_AMBER      = 3,
    parameter int T_REDAMBER   = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_WALK       = 5,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_btn,
    output logic [2:0] rag_main,
    output logic [2:0] rag_side,
    output logic       walk,
    output logic       ped_wait,
    output logic [3:0] phase
);
    import tlights_pkg::*;

    phase_t           state, state_nxt;
    logic             side_lat, side_lat_nxt;
    logic             ped_lat;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    // Timer reload value is one less than the dwell, so a state lasts exactly T cycles.
    function automatic logic [CNT_W-1:0] dwell(input phase_t p);
        case (p)
            PH_MG:          dwell = CNT_W'(T_MAIN_MIN - 1);
            PH_MA, PH_SA:   dwell = CNT_W'(T_AMBER - 1);
            PH_SRA, PH_MRA: dwell = CNT_W'(T_REDAMBER - 1);
            PH_SG:          dwell = CNT_W'(T_SIDE_GREEN - 1);
            PH_WALK:        dwell = CNT_W'(T_WALK - 1);
            default:        dwell = CNT_W'(T_ALLRED - 1);
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            PH_MG:   if (tmr_zero && (side_lat || ped_lat)) state_nxt = PH_MA;
            PH_MA:   if (tmr_zero) state_nxt = PH_AR1;
            PH_AR1:  if (tmr_zero) state_nxt = ped_lat ? PH_WALK : PH_SRA;
            PH_WALK: if (tmr_zero) state_nxt = side_lat ? PH_SRA : PH_MRA;
            PH_SRA:  if (tmr_zero) state_nxt = PH_SG;
            PH_SG:   if (tmr_zero) state_nxt = PH_SA;
            PH_SA:   if (tmr_zero) state_nxt = PH_AR2;
            PH_AR2:  if (tmr_zero) state_nxt = PH_MRA;
            PH_MRA:  if (tmr_zero) state_nxt = PH_MG;
            default: state_nxt = PH_AR2;
        endcase
        tmr_load = (state_nxt != state);
        tmr_val  = dwell(state_nxt);
        // Entering SRA serves the request; clearing beats a same-cycle new request.
        side_lat_nxt = side_lat | side_req;
        if (state_nxt == PH_SRA && state != PH_SRA) side_lat_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PH_AR2;
            rag_main <= RED;
            rag_side <= RED;
            side_lat <= 1'b0;
        end else begin
            state    <= state_nxt;
            rag_main <= main_rag(state_nxt);
            rag_side <= side_rag(state_nxt);
            side_lat <= side_lat_nxt;
        end
    end

`ifdef TLJ_PED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_lat <= 1'b0;
            walk    <= 1'b0;
        end else begin
            if (state_nxt == PH_WALK && state != PH_WALK) ped_lat <= 1'b0;
            else if (ped_btn) ped_lat <= 1'b1;
            walk <= (state_nxt == PH_WALK);
        end
    end
`else
    logic unused_ped_btn;
    assign unused_ped_btn = ped_btn;
    assign ped_lat        = 1'b0;
    assign walk           = 1'b0;
`endif

    assign ped_wait = ped_lat;
    assign phase    = state;

    tlights_dwell_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(T_ALLRED - 1))
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

endmodule

// File: tb/tb_tlights_junction.sv
// Bench for tlights_junction: directed phase-sequence tables, hand-written corner
// sequences and a randomized run against a behavioural junction model.
module tb_tlights_junction;
    import tlights_pkg::*;

    localparam int T_MAIN_MIN   = 8;
    localparam int T_SIDE_GREEN = 6;
    localparam int T_AMBER      = 3;
    localparam int T_REDAMBER   = 2;
    localparam int T_ALLRED     = 1;
    localparam int T_WALK       = 5;
`ifdef TLJ_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       side_req;
    logic       ped_btn;
    logic [2:0] rag_main;
    logic [2:0] rag_side;
    logic       walk;
    logic       ped_wait;
    logic [3:0] phase;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    tlights_junction #(
        .T_MAIN_MIN  (T_MAIN_MIN),
        .T_SIDE_GREEN(T_SIDE_GREEN),
        .T_AMBER     (T_AMBER),
        .T_REDAMBER  (T_REDAMBER),
        .T_ALLRED    (T_ALLRED),
        .T_WALK      (T_WALK),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .side_req(side_req),
        .ped_btn (ped_btn),
        .rag_main(rag_main),
        .rag_side(rag_side),
        .walk    (walk),
        .ped_wait(ped_wait),
        .phase   (phase)
    );

    typedef struct {
        phase_t     ph;
        int         cycles;
        logic [2:0] em;
        logic [2:0] es;
    } run_t;

    run_t side_tab[7];

    // Behavioural model: phase, cycles spent in it, and the two pending requests.
    phase_t m_ph;
    int     m_age;
    bit     m_side;
    bit     m_ped;

    function automatic logic [2:0] exp_main(input phase_t p);
        exp_main = 3'b100;
        if (p == PH_MG)  exp_main = 3'b001;
        if (p == PH_MA)  exp_main = 3'b010;
        if (p == PH_MRA) exp_main = 3'b110;
    endfunction

    function automatic logic [2:0] exp_side(input phase_t p);
        exp_side = 3'b100;
        if (p == PH_SRA) exp_side = 3'b110;
        if (p == PH_SG)  exp_side = 3'b001;
        if (p == PH_SA)  exp_side = 3'b010;
    endfunction

    function automatic int dur(input phase_t p);
        case (p)
            PH_MG:          dur = T_MAIN_MIN;
            PH_MA, PH_SA:   dur = T_AMBER;
            PH_SRA, PH_MRA: dur = T_REDAMBER;
            PH_SG:          dur = T_SIDE_GREEN;
            PH_WALK:        dur = T_WALK;
            default:        dur = T_ALLRED;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input phase_t ph, input logic [2:0] em,
                         input logic [2:0] es, input logic ew, input logic pw);
        n_total++;
        if (phase === ph && rag_main === em && rag_side === es && walk === ew && ped_wait === pw)
            n_pass++;
        else
            $display("FAIL %s t=%0t got phase=%0d main=%b side=%b walk=%b ped_wait=%b want phase=%0d main=%b side=%b walk=%b ped_wait=%b",
                     name, $time, phase, rag_main, rag_side, walk, ped_wait,
                     ph, em, es, ew, pw);
    endtask

    task automatic chk_ph(input string name, input phase_t ph, input logic pw);
        check(name, ph, exp_main(ph), exp_side(ph), ph == PH_WALK, pw);
    endtask

    task automatic check_run(input string name, input phase_t ph, input int n, input logic pw);
        for (int i = 0; i < n; i++) begin
            chk_ph(name, ph, pw);
            tick();
        end
    endtask

    // Side phase from MA to MRA; optionally keep side_req high through MA/AR1
    // and through the first SRA cycle.
    task automatic run_side(input string name, input bit hold, input bit hold_sra);
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < side_tab[r].cycles; c++) begin
                side_req = (hold && (side_tab[r].ph == PH_MA || side_tab[r].ph == PH_AR1)) ||
                           (hold_sra && side_tab[r].ph == PH_SRA && c == 0);
                check(name, side_tab[r].ph, side_tab[r].em, side_tab[r].es, 1'b0, 1'b0);
                tick();
            end
        end
        side_req = 1'b0;
    endtask

    task automatic model_reset();
        m_ph   = PH_AR2;
        m_age  = 0;
        m_side = 1'b0;
        m_ped  = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p);
        phase_t nx;
        bit     ns;
        bit     np;
        nx = m_ph;
        if (m_age + 1 >= dur(m_ph)) begin
            case (m_ph)
                PH_MG:   if (m_side || m_ped) nx = PH_MA;
                PH_MA:   nx = PH_AR1;
                PH_AR1:  nx = m_ped ? PH_WALK : PH_SRA;
                PH_WALK: nx = m_side ? PH_SRA : PH_MRA;
                PH_SRA:  nx = PH_SG;
                PH_SG:   nx = PH_SA;
                PH_SA:   nx = PH_AR2;
                PH_AR2:  nx = PH_MRA;
                default: nx = PH_MG;
            endcase
        end
        ns = (nx == PH_SRA && m_ph != PH_SRA) ? 1'b0 : (m_side | s);
        np = (nx == PH_WALK && m_ph != PH_WALK) ? 1'b0 : (m_ped | (PED_EN & p));
        m_age  = (nx != m_ph) ? 0 : m_age + 1;
        m_ph   = nx;
        m_side = ns;
        m_ped  = np;
    endtask

    task automatic chk_model();
        check("rand", m_ph, exp_main(m_ph), exp_side(m_ph), m_ph == PH_WALK, m_ped);
    endtask

    initial begin
        side_tab[0] = '{PH_MA,  T_AMBER,      3'b010, 3'b100};
        side_tab[1] = '{PH_AR1, T_ALLRED,     3'b100, 3'b100};
        side_tab[2] = '{PH_SRA, T_REDAMBER,   3'b100, 3'b110};
        side_tab[3] = '{PH_SG,  T_SIDE_GREEN, 3'b100, 3'b001};
        side_tab[4] = '{PH_SA,  T_AMBER,      3'b100, 3'b010};
        side_tab[5] = '{PH_AR2, T_ALLRED,     3'b100, 3'b100};
        side_tab[6] = '{PH_MRA, T_REDAMBER,   3'b110, 3'b100};

        rst_n    = 1'b0;
        side_req = 1'b0;
        ped_btn  = 1'b0;

        // Reset held, then release: AR2 1, MRA 2, MG held with no input.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_low", PH_AR2, 3'b100, 3'b100, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        check_run("rst_ar2", PH_AR2, 1, 1'b0);
        check_run("rst_mra", PH_MRA, 2, 1'b0);
        check_run("rst_mg_hold", PH_MG, 50, 1'b0);

        // Fresh MG, side pulse on MG cycle 2: MG lasts exactly 8 cycles.
        rst_n = 1'b0;
        #1;
        check("rst_async", PH_AR2, 3'b100, 3'b100, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        check_run("re_ar2", PH_AR2, 1, 1'b0);
        check_run("re_mra", PH_MRA, 2, 1'b0);
        check_run("mg_c1", PH_MG, 1, 1'b0);
        side_req = 1'b1;
        check_run("mg_c2", PH_MG, 1, 1'b0);
        side_req = 1'b0;
        check_run("mg_min", PH_MG, 6, 1'b0);
        run_side("side_seq", 1'b0, 1'b0);
        check_run("mg_after_side", PH_MG, 20, 1'b0);

        // Late request: latch on edge k, MA on edge k+1.
        side_req = 1'b1;
        check_run("late_req", PH_MG, 1, 1'b0);
        side_req = 1'b0;
        check_run("late_latched", PH_MG, 1, 1'b0);
        run_side("late_seq", 1'b0, 1'b0);

        // side_req held through SRA entry only: clear wins, no second side phase.
        check_run("clr_mg", PH_MG, 10, 1'b0);
        side_req = 1'b1;
        check_run("clr_req", PH_MG, 2, 1'b0);
        run_side("clr_seq", 1'b1, 1'b0);
        check_run("clr_no_repeat", PH_MG, 20, 1'b0);

        // Held one cycle past SRA entry: latch re-sets, second phase after MG minimum.
        side_req = 1'b1;
        check_run("reset_req", PH_MG, 2, 1'b0);
        run_side("reset_seq", 1'b1, 1'b1);
        check_run("reset_mg_min", PH_MG, 8, 1'b0);
        run_side("second_seq", 1'b0, 1'b0);
        check_run("second_mg", PH_MG, 10, 1'b0);

        // Reset in SG cycle 3 with a request pending: request discarded.
        side_req = 1'b1;
        check_run("mid_req", PH_MG, 1, 1'b0);
        side_req = 1'b0;
        check_run("mid_req2", PH_MG, 1, 1'b0);
        check_run("mid_ma", PH_MA, 3, 1'b0);
        check_run("mid_ar1", PH_AR1, 1, 1'b0);
        check_run("mid_sra", PH_SRA, 2, 1'b0);
        side_req = 1'b1;
        check_run("mid_sg1", PH_SG, 1, 1'b0);
        side_req = 1'b0;
        check_run("mid_sg2", PH_SG, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_now", PH_AR2, 3'b100, 3'b100, 1'b0, 1'b0);
        tick();
        check("mid_rst_hold", PH_AR2, 3'b100, 3'b100, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_run("mid_ar2", PH_AR2, 1, 1'b0);
        check_run("mid_mra", PH_MRA, 2, 1'b0);
        check_run("mid_discard", PH_MG, 20, 1'b0);

`ifdef TLJ_PED_EN
        // Pedestrian and side request together: WALK first, then the side phase.
        side_req = 1'b1;
        ped_btn  = 1'b1;
        check_run("prio_req", PH_MG, 1, 1'b0);
        side_req = 1'b0;
        ped_btn  = 1'b0;
        check_run("prio_latched", PH_MG, 1, 1'b1);
        check_run("prio_ma", PH_MA, 3, 1'b1);
        check_run("prio_ar1", PH_AR1, 1, 1'b1);
        check_run("prio_walk", PH_WALK, 5, 1'b0);
        check_run("prio_sra", PH_SRA, 2, 1'b0);
        check_run("prio_sg", PH_SG, 6, 1'b0);
        check_run("prio_sa", PH_SA, 3, 1'b0);
        check_run("prio_ar2", PH_AR2, 1, 1'b0);
        check_run("prio_mra", PH_MRA, 2, 1'b0);
        check_run("prio_mg", PH_MG, 10, 1'b0);
`else
        // Pedestrian button has no effect in this build.
        for (int k = 0; k < 3; k++) begin
            ped_btn = 1'b1;
            check_run("ped_ignored", PH_MG, 1, 1'b0);
            ped_btn = 1'b0;
            check_run("ped_ignored", PH_MG, 4, 1'b0);
        end
        check_run("ped_ignored_hold", PH_MG, 20, 1'b0);
`endif

        // Randomized run against the behavioural model.
        rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            bit s;
            bit p;
            bit r;
            s = ($urandom_range(0, 14) == 0);
            p = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 399) != 0);
            side_req = s;
            ped_btn  = p;
            if (!r) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_model();
            end else begin
                rst_n = 1'b1;
            end
            tick();
            if (rst_n) model_step(s, p);
            else model_reset();
            chk_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
